// File: rtl/fft_pkg.sv
// Shared definitions for the FFT twiddle-address path: ROM geometry,
// sequencer state encoding and the mod-96 adder used by the accumulators.
package fft_pkg;

    localparam int TW_N  = 96;
    localparam int TW_AW = 11;
    localparam int TW_CW = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Both operands are already in [0,TW_N-1], so one conditional subtract is enough.
    function automatic logic [TW_CW-1:0] mod_add96(input logic [TW_CW-1:0] a,
                                                   input logic [TW_CW-1:0] b);
        logic [TW_CW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= (TW_CW+1)'(TW_N)) begin
            sum = sum - (TW_CW+1)'(TW_N);
        end
        return sum[TW_CW-1:0];
    endfunction

endpackage

// File: rtl/tw_mod_acc.sv
// Mod-96 accumulator with synchronous clear and enable; clear wins over enable.
module tw_mod_acc
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [TW_CW-1:0] inc,
    output logic [TW_CW-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en) begin
            value <= mod_add96(value, inc);
        end
    end

endmodule

// File: rtl/twiddle_addr_seq.sv
// Twiddle ROM address sequencer for one N1 x N2 FFT stage: emits
// (n1*k2*S) mod 96 as a valid/ready stream using only adders.
//
// state | meaning
// IDLE  | waiting for start; checks and latches configuration
// RUN   | presenting addresses, advancing on each accepted beat
// DONE  | one-cycle done pulse, then back to IDLE
module twiddle_addr_seq
    import fft_pkg::*;
#(
    parameter int TW_N  = fft_pkg::TW_N,
    parameter int AW    = fft_pkg::TW_AW,
    parameter int CW    = fft_pkg::TW_CW,
    parameter int TW_FF = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] cfg_n1,
    input  logic [CW-1:0] cfg_n2,
    input  logic [CW-1:0] cfg_stride,
    output logic [AW-1:0] addr,
    output logic          addr_valid,
    input  logic          addr_ready,
    output logic          tw_valid,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    seq_state_t state, state_next;

    logic [CW-1:0]   n1_sh, n2_sh, stride_sh;
    logic [CW-1:0]   n1_cnt, k2_cnt;
    logic [CW-1:0]   acc, step;
    logic [2*CW-1:0] cfg_area;
    logic            cfg_bad;
    logic            launch;
    logic            fire;
    logic            last_n1, last_k2;
    logic            acc_clr, acc_en;
    logic            step_clr, step_en;
    logic            cfg_err_q;

    // The product is only a legality check on the configuration, not part of the address path.
    assign cfg_area = {{CW{1'b0}}, cfg_n1} * {{CW{1'b0}}, cfg_n2};
    assign cfg_bad  = (cfg_n1 == '0) || (cfg_n2 == '0) ||
                      (cfg_stride >= CW'(TW_N)) || (cfg_area > (2*CW)'(TW_N));

    assign last_n1 = (n1_cnt == n1_sh - CW'(1));
    assign last_k2 = (k2_cnt == n2_sh - CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        fire       = 1'b0;
        addr_valid = 1'b0;
        done       = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        step_clr   = 1'b0;
        step_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !cfg_bad) begin
                    launch     = 1'b1;
                    acc_clr    = 1'b1;
                    step_clr   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                addr_valid = 1'b1;
                fire       = addr_ready;
                if (fire) begin
                    if (!last_n1) begin
                        acc_en = 1'b1;
                    end else begin
                        acc_clr = 1'b1;
                        if (!last_k2) begin
                            step_en = 1'b1;
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n1_sh     <= '0;
            n2_sh     <= '0;
            stride_sh <= '0;
            n1_cnt    <= '0;
            k2_cnt    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= (state == IDLE) && start && cfg_bad;
            if (state == IDLE && start) begin
                n1_sh     <= cfg_n1;
                n2_sh     <= cfg_n2;
                stride_sh <= cfg_stride;
            end
            if (launch) begin
                n1_cnt <= '0;
                k2_cnt <= '0;
            end else if (fire) begin
                if (!last_n1) begin
                    n1_cnt <= n1_cnt + CW'(1);
                end else begin
                    n1_cnt <= '0;
                    if (!last_k2) begin
                        k2_cnt <= k2_cnt + CW'(1);
                    end
                end
            end
        end
    end

    tw_mod_acc u_acc (
        .clk   (clk),
        .rst   (rst),
        .clr   (acc_clr),
        .en    (acc_en),
        .inc   (step),
        .value (acc)
    );

    tw_mod_acc u_step (
        .clk   (clk),
        .rst   (rst),
        .clr   (step_clr),
        .en    (step_en),
        .inc   (stride_sh),
        .value (step)
    );

    assign addr    = {{(AW-CW){1'b0}}, acc};
    assign busy    = (state != IDLE);
    assign cfg_err = cfg_err_q;

    generate
        if (TW_FF == 0) begin : g_tw_comb
            assign tw_valid = fire;
        end else begin : g_tw_reg
            logic tw_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    tw_q <= 1'b0;
                end else begin
                    tw_q <= fire;
                end
            end
            assign tw_valid = tw_q;
        end
    endgenerate

endmodule
